// File: rtl/mtip_mm_bridge_pkg.sv
// Shared types and constants for the MTIP host-side bridge.
// The bridge state is one-hot so oBUSY and waitrequest decode from single bits.
package mtip_pkg;

  localparam int MTIP_MM_ADDR_W = 14;
  localparam int MTIP_MM_DATA_W = 64;

  localparam logic [MTIP_MM_DATA_W-1:0] MTIP_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [2:0]                MTIP_STALE_MAX    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b001,
    ST_RD_WAIT    = 3'b010,
    ST_FLUSH_WAIT = 3'b100
  } bridge_state_t;

endpackage

// File: rtl/mtip_rd_timer.sv
// Read-response watchdog: held at zero by clear, counts while enabled,
// and flags expiry on the last cycle of the RD_TIMEOUT window.
module mtip_rd_timer #(
  parameter logic [19:0] RD_TIMEOUT = 20'd100000
) (
  input  logic iCLK_100M,
  input  logic iRST_100M_N,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [19:0] count;

  assign expired = enable && (count == RD_TIMEOUT - 20'd1);

  always_ff @(posedge iCLK_100M or negedge iRST_100M_N) begin
    if (!iRST_100M_N) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 20'd1;
    end
  end

endmodule

// File: rtl/mtip_mm_bridge.sv
// Avalon-MM slave that turns host accesses into single-cycle PIO request pulses,
// bounds posted writes with a forced flush read, and times out lost reads.
module mtip_mm_bridge
  import mtip_pkg::*;
#(
  parameter logic [2:0]  MAX_POSTED = 3'd6,
  parameter logic [13:0] FLUSH_ADDR = 14'h0000,
  parameter logic [19:0] RD_TIMEOUT = 20'd100000
) (
  input  logic                      iCLK_100M,
  input  logic                      iRST_100M_N,
  input  logic [MTIP_MM_ADDR_W-1:0] avs_address,
  input  logic                      avs_write,
  input  logic                      avs_read,
  input  logic [MTIP_MM_DATA_W-1:0] avs_writedata,
  output logic                      avs_waitrequest,
  output logic [MTIP_MM_DATA_W-1:0] avs_readdata,
  output logic                      avs_readdatavalid,
  output logic [MTIP_MM_DATA_W-1:0] oMTIP_MM_WR_DATA,
  output logic [MTIP_MM_ADDR_W-1:0] oMTIP_MM_ADDR,
  output logic                      oMTIP_MM_WR_EN,
  output logic                      oMTIP_MM_RD_EN,
  input  logic [MTIP_MM_DATA_W-1:0] iMTIP_MM_RD_DATA,
  input  logic                      iMTIP_MM_RD_DATA_V,
  output logic [15:0]               oTIMEOUT_CNT,
  output logic                      oPROTO_ERR,
  output logic                      oBUSY
);

  bridge_state_t state;
  logic [2:0]    posted_cnt;
  logic [2:0]    stale_cnt;
  logic          is_idle;
  logic          accept;
  logic          need_flush;
  logic          orphan;
  logic          real_valid;
  logic          expired;
  logic          timeout;

  assign is_idle         = (state == ST_IDLE);
  assign oBUSY           = !is_idle;
  assign avs_waitrequest = !is_idle || (posted_cnt == MAX_POSTED);
  assign accept          = (avs_write || avs_read) && !avs_waitrequest;
  assign need_flush      = is_idle && (posted_cnt == MAX_POSTED);

  // Responses to reads we already timed out are still owed by the PIO stage.
  assign orphan     = iMTIP_MM_RD_DATA_V && (stale_cnt != 3'd0);
  assign real_valid = iMTIP_MM_RD_DATA_V && (stale_cnt == 3'd0) && !is_idle;
  assign timeout    = expired && !real_valid;

  mtip_rd_timer #(
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_rd_timer (
    .iCLK_100M   (iCLK_100M),
    .iRST_100M_N (iRST_100M_N),
    .clear       (is_idle),
    .enable      (!is_idle),
    .expired     (expired)
  );

  always_ff @(posedge iCLK_100M or negedge iRST_100M_N) begin
    if (!iRST_100M_N) begin
      state             <= ST_IDLE;
      posted_cnt        <= '0;
      stale_cnt         <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
      oMTIP_MM_WR_DATA  <= '0;
      oMTIP_MM_ADDR     <= '0;
      oMTIP_MM_WR_EN    <= 1'b0;
      oMTIP_MM_RD_EN    <= 1'b0;
      oTIMEOUT_CNT      <= '0;
      oPROTO_ERR        <= 1'b0;
    end else begin
      oMTIP_MM_WR_EN    <= 1'b0;
      oMTIP_MM_RD_EN    <= 1'b0;
      avs_readdatavalid <= 1'b0;

      if (orphan && !timeout) begin
        stale_cnt <= stale_cnt - 3'd1;
      end else if (timeout && !orphan && (stale_cnt != MTIP_STALE_MAX)) begin
        stale_cnt <= stale_cnt + 3'd1;
      end

      if (timeout && (oTIMEOUT_CNT != 16'hFFFF)) begin
        oTIMEOUT_CNT <= oTIMEOUT_CNT + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (need_flush) begin
            oMTIP_MM_RD_EN <= 1'b1;
            oMTIP_MM_ADDR  <= FLUSH_ADDR;
            state          <= ST_FLUSH_WAIT;
          end else if (accept && avs_write) begin
            oMTIP_MM_WR_EN   <= 1'b1;
            oMTIP_MM_ADDR    <= avs_address;
            oMTIP_MM_WR_DATA <= avs_writedata;
            posted_cnt       <= posted_cnt + 3'd1;
            if (avs_read) begin
              oPROTO_ERR <= 1'b1;
            end
          end else if (accept && avs_read) begin
            oMTIP_MM_RD_EN <= 1'b1;
            oMTIP_MM_ADDR  <= avs_address;
            state          <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (real_valid) begin
            avs_readdata      <= iMTIP_MM_RD_DATA;
            avs_readdatavalid <= 1'b1;
            posted_cnt        <= '0;
            state             <= ST_IDLE;
          end else if (timeout) begin
            avs_readdata      <= MTIP_TIMEOUT_DATA;
            avs_readdatavalid <= 1'b1;
            state             <= ST_IDLE;
          end
        end
        ST_FLUSH_WAIT: begin
          // A lost flush still releases the posted window, otherwise the host stalls forever.
          if (real_valid || timeout) begin
            posted_cnt <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtip_mm_bridge.sv
// Directed bench for mtip_mm_bridge with a short read timeout.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_mtip_mm_bridge;

  logic        clk;
  logic        rst_n;
  logic [13:0] avs_address;
  logic        avs_write;
  logic        avs_read;
  logic [63:0] avs_writedata;
  logic        avs_waitrequest;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [63:0] mm_wr_data;
  logic [13:0] mm_addr;
  logic        mm_wr_en;
  logic        mm_rd_en;
  logic [63:0] mm_rd_data;
  logic        mm_rd_data_v;
  logic [15:0] timeout_cnt;
  logic        proto_err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mtip_mm_bridge #(
    .MAX_POSTED (3'd6),
    .FLUSH_ADDR (14'h0000),
    .RD_TIMEOUT (20'd20)
  ) dut (
    .iCLK_100M          (clk),
    .iRST_100M_N        (rst_n),
    .avs_address        (avs_address),
    .avs_write          (avs_write),
    .avs_read           (avs_read),
    .avs_writedata      (avs_writedata),
    .avs_waitrequest    (avs_waitrequest),
    .avs_readdata       (avs_readdata),
    .avs_readdatavalid  (avs_readdatavalid),
    .oMTIP_MM_WR_DATA   (mm_wr_data),
    .oMTIP_MM_ADDR      (mm_addr),
    .oMTIP_MM_WR_EN     (mm_wr_en),
    .oMTIP_MM_RD_EN     (mm_rd_en),
    .iMTIP_MM_RD_DATA   (mm_rd_data),
    .iMTIP_MM_RD_DATA_V (mm_rd_data_v),
    .oTIMEOUT_CNT       (timeout_cnt),
    .oPROTO_ERR         (proto_err),
    .oBUSY              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a host access, wait (bounded) for waitrequest low, then let the edge accept it.
  task automatic host_access(input string tag, input logic wr, input logic rd,
                             input logic [13:0] a, input logic [63:0] d);
    int n;
    avs_write     = wr;
    avs_read      = rd;
    avs_address   = a;
    avs_writedata = d;
    n = 0;
    while (avs_waitrequest && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_waitreq"}, avs_waitrequest, 1'b0);
    tick();
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic pio_respond(input logic [63:0] d);
    mm_rd_data   = d;
    mm_rd_data_v = 1'b1;
    tick();
    mm_rd_data_v = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    rst_n         = 1'b0;
    avs_address   = '0;
    avs_write     = 1'b0;
    avs_read      = 1'b0;
    avs_writedata = '0;
    mm_rd_data    = '0;
    mm_rd_data_v  = 1'b0;
    repeat (3) tick();

    check("rst_busy", busy, 1'b0);
    check("rst_waitreq", avs_waitrequest, 1'b0);
    check("rst_wr_en", mm_wr_en, 1'b0);
    check("rst_rd_en", mm_rd_en, 1'b0);
    check("rst_rdv", avs_readdatavalid, 1'b0);
    check("rst_readdata", avs_readdata, 64'h0);
    check("rst_tocnt", timeout_cnt, 16'h0);
    check("rst_proto", proto_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single write: one-cycle pulse with registered address/data.
    host_access("wr1", 1'b1, 1'b0, 14'h020, 64'h1234);
    check("wr1_wr_en", mm_wr_en, 1'b1);
    check("wr1_addr", mm_addr, 14'h020);
    check("wr1_data", mm_wr_data, 64'h1234);
    check("wr1_rd_en", mm_rd_en, 1'b0);
    tick();
    check("wr1_wr_en_drop", mm_wr_en, 1'b0);

    // Read with response five cycles after the request pulse.
    host_access("rd1", 1'b0, 1'b1, 14'h008, 64'h0);
    check("rd1_rd_en", mm_rd_en, 1'b1);
    check("rd1_addr", mm_addr, 14'h008);
    check("rd1_busy", busy, 1'b1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (!avs_waitrequest) seen++;
      tick();
    end
    check("rd1_waitreq_held", seen, 0);
    pio_respond(64'hA5);
    check("rd1_rdv", avs_readdatavalid, 1'b1);
    check("rd1_data", avs_readdata, 64'hA5);
    check("rd1_idle", busy, 1'b0);
    tick();
    check("rd1_rdv_drop", avs_readdatavalid, 1'b0);

    // Six posted writes force a flush before the seventh access.
    for (int i = 0; i < 6; i++) begin
      host_access("pw", 1'b1, 1'b0, 14'(14'h100 + i), 64'(i));
    end
    check("pw_stall", avs_waitrequest, 1'b1);
    avs_write     = 1'b1;
    avs_address   = 14'h030;
    avs_writedata = 64'h77;
    tick();
    check("flush_rd_en", mm_rd_en, 1'b1);
    check("flush_addr", mm_addr, 14'h0000);
    check("flush_wr_en", mm_wr_en, 1'b0);
    check("flush_busy", busy, 1'b1);
    tick();
    tick();
    check("flush_stall", avs_waitrequest, 1'b1);
    pio_respond(64'h999);
    check("flush_no_rdv", avs_readdatavalid, 1'b0);
    check("flush_released", avs_waitrequest, 1'b0);
    tick();
    avs_write = 1'b0;
    check("w7_wr_en", mm_wr_en, 1'b1);
    check("w7_addr", mm_addr, 14'h030);
    check("w7_data", mm_wr_data, 64'h77);

    // Lost read times out; the late response is then discarded as an orphan.
    host_access("to", 1'b0, 1'b1, 14'h010, 64'h0);
    check("to_rd_en", mm_rd_en, 1'b1);
    n = 0;
    while (!avs_readdatavalid && n < 100) begin
      tick();
      n++;
    end
    check("to_rdv", avs_readdatavalid, 1'b1);
    check("to_latency", n, 20);
    check("to_data", avs_readdata, 64'hDEAD_BEEF_DEAD_BEEF);
    check("to_cnt", timeout_cnt, 16'd1);
    check("to_posted_kept", avs_waitrequest, 1'b0);
    host_access("rd2", 1'b0, 1'b1, 14'h018, 64'h0);
    tick();
    pio_respond(64'h111);
    check("orphan_no_rdv", avs_readdatavalid, 1'b0);
    check("orphan_busy", busy, 1'b1);
    tick();
    pio_respond(64'h222);
    check("rd2_rdv", avs_readdatavalid, 1'b1);
    check("rd2_data", avs_readdata, 64'h222);
    check("rd2_tocnt", timeout_cnt, 16'd1);

    // Simultaneous read and write: write wins, error flag sticks.
    tick();
    check("pe_before", proto_err, 1'b0);
    host_access("pe", 1'b1, 1'b1, 14'h040, 64'hBEEF);
    check("pe_wr_en", mm_wr_en, 1'b1);
    check("pe_rd_en", mm_rd_en, 1'b0);
    check("pe_addr", mm_addr, 14'h040);
    check("pe_flag", proto_err, 1'b1);
    check("pe_busy", busy, 1'b0);
    tick();
    check("pe_sticky", proto_err, 1'b1);

    // Reset while a read is outstanding.
    host_access("rr", 1'b0, 1'b1, 14'h050, 64'h0);
    repeat (3) tick();
    check("rr_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #2;
    check("rr_busy", busy, 1'b0);
    check("rr_tocnt", timeout_cnt, 16'h0);
    check("rr_proto", proto_err, 1'b0);
    check("rr_waitreq", avs_waitrequest, 1'b0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (avs_readdatavalid || busy) seen++;
    end
    check("rr_quiet", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mtip_mm_bridge.md
Name: mtip_mm_bridge

Overview:
Host-facing Avalon-MM slave that converts host register accesses into the single-cycle write/read request pulses consumed by the MTIP PIO stage, and returns the PIO stage's read data to the host. It sits directly upstream of the PIO stage on iCLK_100M.
- The PIO command FIFO (8 deep) has no backpressure, so this block bounds posted writes itself.
- It forces a flush read once MAX_POSTED writes are outstanding.
- It times out lost reads and discards orphaned late responses.

Parameters:
- MAX_POSTED, 6: posted writes allowed before a forced flush read. Must be at most 6, which leaves one FIFO slot for the link-control injection and one for the flush read.
- FLUSH_ADDR, 14'h0000: read-only MTIP register address used for the flush read.
- RD_TIMEOUT, 20'd100000: cycles to wait for read data before returning TIMEOUT_DATA (1 ms).

Ports:
- iCLK_100M  in  1  clock
- iRST_100M_N  in  1  asynchronous active-low reset
- avs_address  in  14  host register address
- avs_write  in  1  host write strobe
- avs_read  in  1  host read strobe
- avs_writedata  in  64  host write data
- avs_waitrequest  out  1  host stall
- avs_readdata  out  64  host read data
- avs_readdatavalid  out  1  host read data valid, 1-cycle pulse
- oMTIP_MM_WR_DATA  out  64  write data to the PIO stage
- oMTIP_MM_ADDR  out  14  address to the PIO stage
- oMTIP_MM_WR_EN  out  1  write request pulse
- oMTIP_MM_RD_EN  out  1  read request pulse
- iMTIP_MM_RD_DATA  in  64  read data from the PIO stage
- iMTIP_MM_RD_DATA_V  in  1  read data valid pulse
- oTIMEOUT_CNT  out  16  saturating count of read timeouts
- oPROTO_ERR  out  1  sticky: avs_read and avs_write were both high
- oBUSY  out  1  state is not IDLE

Behaviour:
- Reset and clocking: reset iRST_100M_N, asynchronous, active-low; clock iCLK_100M.
- Reset values:
  - State = IDLE; posted_cnt = 0; stale_cnt = 0; timer = 0.
  - All output pulses = 0; oTIMEOUT_CNT = 0; oPROTO_ERR = 0.
  - avs_readdata and oMTIP_MM_* data/address = 0.
- Reset mid-operation drops any in-flight transaction. The PIO stage shares this reset, so no stale response can follow.
- States: IDLE, RD_WAIT, FLUSH_WAIT (one-hot).
- avs_waitrequest (combinational) = ~IDLE | (posted_cnt == MAX_POSTED).
- Accept = (avs_write | avs_read) & ~avs_waitrequest.
- IDLE, write accepted in cycle N:
  - Address and data are registered; oMTIP_MM_WR_EN is high in cycle N+1 only.
  - posted_cnt increments; state stays IDLE.
- IDLE, read accepted in cycle N:
  - oMTIP_MM_RD_EN is high in cycle N+1; state goes to RD_WAIT; timer is cleared.
- Read and write high together: treated as a write, the read is dropped, and oPROTO_ERR is set (sticky until reset).
- IDLE with posted_cnt == MAX_POSTED:
  - Issue oMTIP_MM_RD_EN with FLUSH_ADDR next cycle; state goes to FLUSH_WAIT; timer is cleared.
  - The flush takes priority over any pending host access.
- RD_WAIT / FLUSH_WAIT: timer increments each cycle.
- iMTIP_MM_RD_DATA_V with stale_cnt > 0 is an orphan. It is discarded, stale_cnt decrements, and the state is unchanged.
- iMTIP_MM_RD_DATA_V with stale_cnt == 0 in RD_WAIT:
  - avs_readdata is set to the data and avs_readdatavalid pulses on the next cycle.
  - posted_cnt clears, because responses are in order and all earlier writes are complete.
  - State goes to IDLE.
- iMTIP_MM_RD_DATA_V with stale_cnt == 0 in FLUSH_WAIT: data is discarded, posted_cnt clears, state goes to IDLE. No host pulse.
- Timeout (timer == RD_TIMEOUT-1 with no valid data):
  - oTIMEOUT_CNT increments, saturating at 16'hFFFF.
  - stale_cnt increments, saturating at 7.
  - RD_WAIT: avs_readdata = 64'hDEAD_BEEF_DEAD_BEEF and avs_readdatavalid pulses; state goes to IDLE; posted_cnt is kept.
  - FLUSH_WAIT: posted_cnt clears (prevents deadlock); state goes to IDLE.
  - If valid data and timeout occur in the same cycle, valid data wins.
- iMTIP_MM_RD_DATA_V in IDLE with stale_cnt == 0 is ignored.
- Latencies:
  - Host request to PIO pulse: 1 cycle.
  - PIO valid to host valid: 1 cycle.
  - At most one read outstanding toward the PIO stage from this block.

Decomposition:
- Package mtip_pkg holds:
  - The bridge state enum.
  - MTIP_MM_ADDR_W = 14 and MTIP_MM_DATA_W = 64.
  - MTIP_TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF.
  - MTIP_STALE_MAX = 7.
- One natural sub-module, mtip_rd_timer: clear/enable timer with expiry flag, parameterised by RD_TIMEOUT.

Test Plan:
- Write addr 14'h020 data 64'h1234 -> oMTIP_MM_WR_EN for exactly 1 cycle with ADDR 14'h020 and WR_DATA 64'h1234; avs_waitrequest stays low.
- Read addr 14'h008; drive RD_DATA_V with 64'hA5 five cycles after RD_EN -> avs_readdatavalid pulses one cycle later with 64'hA5; waitrequest is high throughout RD_WAIT.
- 6 back-to-back writes -> 7th access is stalled; RD_EN issued with FLUSH_ADDR; RD_DATA_V returns -> posted_cnt is 0, no avs_readdatavalid, 7th access is accepted.
- Read with no response, RD_TIMEOUT = 20 -> after 20 cycles readdatavalid pulses with 64'hDEAD_BEEF_DEAD_BEEF and oTIMEOUT_CNT = 1. Then issue a new read: the late V is discarded and the second V returns to the host.
- avs_read and avs_write high in the same cycle -> only WR_EN pulses and oPROTO_ERR = 1.
- Assert reset while in RD_WAIT -> oBUSY = 0, counters = 0, no readdatavalid after release.
